// File: rtl/screen_timing_if.sv
// Raster timing bundle: mode request in, counters, strobes and syncs out.
interface screen_timing_if #(
    parameter int HC_W         = 9,
    parameter int VC_W         = 9,
    parameter int PIX_DIV_LOG2 = 2
);
    logic [1:0]              mode_req;
    logic [1:0]              mode_cur;
    logic [PIX_DIV_LOG2-1:0] sub;
    logic [HC_W-1:0]         hc;
    logic [VC_W-1:0]         vc;
    logic                    ce_pix;
    logic                    line_start;
    logic                    frame_start;
    logic                    active;
    logic                    blank;
    logic                    hsync;
    logic                    vsync;
    logic                    csync;
    logic                    blink;

    modport master (
        input  mode_req,
        output mode_cur, sub, hc, vc, ce_pix, line_start, frame_start,
               active, blank, hsync, vsync, csync, blink
    );

    modport slave (
        output mode_req,
        input  mode_cur, sub, hc, vc, ce_pix, line_start, frame_start,
               active, blank, hsync, vsync, csync, blink
    );
endinterface

// File: rtl/screen_timing_gen.sv
// Raster timing generator for 48K / 128K / Pentagon at clk28; mode changes
// take effect only at the frame wrap so the raster never tears.
module screen_timing_gen #(
    parameter int HC_W         = 9,
    parameter int VC_W         = 9,
    parameter int PIX_DIV_LOG2 = 2,
    parameter int BLINK_W      = 5,
    parameter int SYNC_ACT_LOW = 1
) (
    input  logic             clk28,
    input  logic             rst,
    screen_timing_if.master  tim
);
    localparam logic [PIX_DIV_LOG2-1:0] SUB_MAX   = '1;
    localparam logic                    SYNC_IDLE = (SYNC_ACT_LOW != 0);

    if ((456 >= (1 << HC_W)) || (320 >= (1 << VC_W)) || (PIX_DIV_LOG2 < 1)) begin : g_bad_param
        $error("screen_timing_gen: HC_W/VC_W too narrow for raster totals or PIX_DIV_LOG2 < 1");
    end

    function automatic logic [1:0] canon_mode(input logic [1:0] m);
        return (m == 2'd3) ? 2'd0 : m;
    endfunction

    logic [PIX_DIV_LOG2-1:0] sub_q, sub_d;
    logic [HC_W-1:0]         hc_q, hc_d;
    logic [VC_W-1:0]         vc_q, vc_d;
    logic [1:0]              mode_cur_q, mode_cur_d;
    logic [BLINK_W-1:0]      frame_q, frame_d;
    logic                    active_q, active_d;
    logic                    blank_q, blank_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    csync_q, csync_d;

    logic [HC_W-1:0] h_last, hb_from, hb_to, hs_from, hs_to;
    logic [VC_W-1:0] v_last, vs_from, vs_to;
    logic            sub_wrap, h_wrap, f_wrap;
    logic            hs_act, vs_act, hb_act;

    // Raster table for the mode in effect; V blank shares the V sync window.
    always_comb begin
        h_last  = HC_W'(447);
        hb_from = HC_W'(312);
        hb_to   = HC_W'(408);
        hs_from = HC_W'(329);
        hs_to   = HC_W'(362);
        v_last  = VC_W'(311);
        vs_from = VC_W'(248);
        vs_to   = VC_W'(256);
        case (mode_cur_q)
            2'd1: begin
                h_last  = HC_W'(455);
                hb_to   = HC_W'(416);
                hs_from = HC_W'(337);
                hs_to   = HC_W'(370);
                v_last  = VC_W'(310);
                vs_from = VC_W'(247);
                vs_to   = VC_W'(255);
            end
            2'd2: begin
                hb_from = HC_W'(317);
                hb_to   = HC_W'(402);
                v_last  = VC_W'(319);
            end
            default: ;
        endcase
    end

    always_comb begin
        sub_wrap   = (sub_q == SUB_MAX);
        h_wrap     = sub_wrap && (hc_q == h_last);
        f_wrap     = h_wrap && (vc_q == v_last);

        sub_d      = sub_q + PIX_DIV_LOG2'(1);
        hc_d       = hc_q;
        vc_d       = vc_q;
        mode_cur_d = mode_cur_q;
        frame_d    = frame_q;
        if (sub_wrap) begin
            hc_d = h_wrap ? '0 : hc_q + HC_W'(1);
        end
        if (h_wrap) begin
            vc_d = f_wrap ? '0 : vc_q + VC_W'(1);
        end
        if (f_wrap) begin
            mode_cur_d = canon_mode(tim.mode_req);
            frame_d    = frame_q + BLINK_W'(1);
        end

        hs_act   = (hc_q >= hs_from) && (hc_q < hs_to);
        hb_act   = (hc_q >= hb_from) && (hc_q < hb_to);
        vs_act   = (vc_q >= vs_from) && (vc_q < vs_to);
        active_d = (hc_q < HC_W'(256)) && (vc_q < VC_W'(192));
        blank_d  = hb_act || vs_act;
        hsync_d  = hs_act ^ SYNC_IDLE;
        vsync_d  = vs_act ^ SYNC_IDLE;
        // Composite sync inverts hsync during the vertical pulse.
        csync_d  = (hs_act ^ vs_act) ^ SYNC_IDLE;
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            sub_q      <= '0;
            hc_q       <= '0;
            vc_q       <= '0;
            mode_cur_q <= 2'd0;
            frame_q    <= '0;
            active_q   <= 1'b0;
            blank_q    <= 1'b1;
            hsync_q    <= SYNC_IDLE;
            vsync_q    <= SYNC_IDLE;
            csync_q    <= SYNC_IDLE;
        end else begin
            sub_q      <= sub_d;
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            mode_cur_q <= mode_cur_d;
            frame_q    <= frame_d;
            active_q   <= active_d;
            blank_q    <= blank_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            csync_q    <= csync_d;
        end
    end

    assign tim.mode_cur    = mode_cur_q;
    assign tim.sub         = sub_q;
    assign tim.hc          = hc_q;
    assign tim.vc          = vc_q;
    assign tim.ce_pix      = sub_wrap;
    assign tim.line_start  = (sub_q == '0) && (hc_q == '0);
    assign tim.frame_start = (sub_q == '0) && (hc_q == '0) && (vc_q == '0);
    assign tim.active      = active_q;
    assign tim.blank       = blank_q;
    assign tim.hsync       = hsync_q;
    assign tim.vsync       = vsync_q;
    assign tim.csync       = csync_q;
    assign tim.blink       = frame_q[BLINK_W-1];
endmodule

// File: tb/tb_screen_timing_gen.sv
// Bench for screen_timing_gen: two instances (active-low and active-high syncs)
// run in lockstep against a position-based raster model.
module tb_screen_timing_gen;
    localparam int P = 4;
    localparam int HT  [3] = '{448, 456, 448};
    localparam int HB0 [3] = '{312, 312, 317};
    localparam int HB1 [3] = '{408, 416, 402};
    localparam int HS0 [3] = '{329, 337, 329};
    localparam int HS1 [3] = '{362, 370, 362};
    localparam int VT  [3] = '{312, 311, 320};
    localparam int VS0 [3] = '{248, 247, 248};
    localparam int VS1 [3] = '{256, 255, 256};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode_req = 2'd0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    screen_timing_if #(.HC_W(9), .VC_W(9), .PIX_DIV_LOG2(2)) bus_lo ();
    screen_timing_if #(.HC_W(9), .VC_W(9), .PIX_DIV_LOG2(2)) bus_hi ();
    assign bus_lo.mode_req = mode_req;
    assign bus_hi.mode_req = mode_req;

    screen_timing_gen #(.HC_W(9), .VC_W(9), .PIX_DIV_LOG2(2), .BLINK_W(5), .SYNC_ACT_LOW(1))
        u_dut_lo (.clk28(clk), .rst(rst), .tim(bus_lo));
    screen_timing_gen #(.HC_W(9), .VC_W(9), .PIX_DIV_LOG2(2), .BLINK_W(5), .SYNC_ACT_LOW(0))
        u_dut_hi (.clk28(clk), .rst(rst), .tim(bus_hi));

    // Model: linear position within the frame, decoded with plain arithmetic.
    int m_pos = 0, m_mode = 0, m_frames = 0;
    bit m_act = 0, m_blk = 1, m_hs = 0, m_vs = 0;
    int j_pos = 0, j_mode = 0, j_seq = 0, j_seen = 0;
    int eff_pos, eff_mode;
    assign eff_pos  = (j_seq != j_seen) ? j_pos  : m_pos;
    assign eff_mode = (j_seq != j_seen) ? j_mode : m_mode;

    function automatic int hc_of(input int p, input int m);
        return (p / P) % HT[m];
    endfunction
    function automatic int vc_of(input int p, input int m);
        return p / (P * HT[m]);
    endfunction
    function automatic int canon(input logic [1:0] r);
        return (r == 2'd3) ? 0 : int'(r);
    endfunction
    function automatic bit in_rng(input int x, input int lo, input int hi);
        return (x >= lo) && (x < hi);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos <= 0; m_mode <= 0; m_frames <= 0;
            m_act <= 0; m_blk <= 1; m_hs <= 0; m_vs <= 0;
            j_seen <= j_seq;
        end else begin
            m_act <= (hc_of(eff_pos, eff_mode) < 256) && (vc_of(eff_pos, eff_mode) < 192);
            m_blk <= in_rng(hc_of(eff_pos, eff_mode), HB0[eff_mode], HB1[eff_mode]) ||
                     in_rng(vc_of(eff_pos, eff_mode), VS0[eff_mode], VS1[eff_mode]);
            m_hs  <= in_rng(hc_of(eff_pos, eff_mode), HS0[eff_mode], HS1[eff_mode]);
            m_vs  <= in_rng(vc_of(eff_pos, eff_mode), VS0[eff_mode], VS1[eff_mode]);
            if (eff_pos + 1 == P * HT[eff_mode] * VT[eff_mode]) begin
                m_pos    <= 0;
                m_mode   <= canon(mode_req);
                m_frames <= (m_frames + 1) % 32;
            end else begin
                m_pos  <= eff_pos + 1;
                m_mode <= eff_mode;
            end
            j_seen <= j_seq;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int ms, mh, mv;
        ms = m_pos % P;
        mh = hc_of(m_pos, m_mode);
        mv = vc_of(m_pos, m_mode);
        chk("sub", 32'(bus_lo.sub), ms);
        chk("hc", 32'(bus_lo.hc), mh);
        chk("vc", 32'(bus_lo.vc), mv);
        chk("mode_cur", 32'(bus_lo.mode_cur), m_mode);
        chk("ce_pix", 32'(bus_lo.ce_pix), 32'(ms == P - 1));
        chk("line_start", 32'(bus_lo.line_start), 32'(ms == 0 && mh == 0));
        chk("frame_start", 32'(bus_lo.frame_start), 32'(ms == 0 && mh == 0 && mv == 0));
        chk("blink", 32'(bus_lo.blink), 32'(m_frames >= 16));
        chk("active", 32'(bus_lo.active), 32'(m_act));
        chk("blank", 32'(bus_lo.blank), 32'(m_blk));
        chk("hsync_lo", 32'(bus_lo.hsync), 32'(!m_hs));
        chk("vsync_lo", 32'(bus_lo.vsync), 32'(!m_vs));
        chk("csync_lo", 32'(bus_lo.csync), 32'(!(m_hs ^ m_vs)));
        chk("hc_hi", 32'(bus_hi.hc), mh);
        chk("hsync_hi", 32'(bus_hi.hsync), 32'(m_hs));
        chk("vsync_hi", 32'(bus_hi.vsync), 32'(m_vs));
        chk("csync_hi", 32'(bus_hi.csync), 32'(m_hs ^ m_vs));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // Preload counter state in both instances (and the model) to reach far raster positions quickly.
    task automatic jump(input int s, input int h, input int v, input int m);
        force u_dut_lo.sub_q = 2'(s);       force u_dut_hi.sub_q = 2'(s);
        force u_dut_lo.hc_q = 9'(h);        force u_dut_hi.hc_q = 9'(h);
        force u_dut_lo.vc_q = 9'(v);        force u_dut_hi.vc_q = 9'(v);
        force u_dut_lo.mode_cur_q = 2'(m);  force u_dut_hi.mode_cur_q = 2'(m);
        release u_dut_lo.sub_q;       release u_dut_hi.sub_q;
        release u_dut_lo.hc_q;        release u_dut_hi.hc_q;
        release u_dut_lo.vc_q;        release u_dut_hi.vc_q;
        release u_dut_lo.mode_cur_q;  release u_dut_hi.mode_cur_q;
        j_pos  = ((v * HT[m]) + h) * P + s;
        j_mode = m;
        j_seq++;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1 check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    typedef struct {
        int mode; int hc; int vc;
        bit act; bit blk; bit hs; bit vs;
    } vec_t;

    vec_t vt [32] = '{
        '{0,   0,   0, 1, 0, 0, 0}, '{0, 255, 191, 1, 0, 0, 0},
        '{0, 256, 191, 0, 0, 0, 0}, '{0, 255, 192, 0, 0, 0, 0},
        '{0, 311,  10, 0, 0, 0, 0}, '{0, 312,  10, 0, 1, 0, 0},
        '{0, 328,  10, 0, 1, 0, 0}, '{0, 329,  10, 0, 1, 1, 0},
        '{0, 361,  10, 0, 1, 1, 0}, '{0, 362,  10, 0, 1, 0, 0},
        '{0, 407,  10, 0, 1, 0, 0}, '{0, 408,  10, 0, 0, 0, 0},
        '{0,   0, 247, 0, 0, 0, 0}, '{0,   0, 248, 0, 1, 0, 1},
        '{0, 340, 255, 0, 1, 1, 1}, '{0,   0, 256, 0, 0, 0, 0},
        '{1, 336,  10, 0, 1, 0, 0}, '{1, 337,  10, 0, 1, 1, 0},
        '{1, 369,  10, 0, 1, 1, 0}, '{1, 370,  10, 0, 1, 0, 0},
        '{1, 415,  10, 0, 1, 0, 0}, '{1, 416,  10, 0, 0, 0, 0},
        '{1,   0, 246, 0, 0, 0, 0}, '{1,   0, 247, 0, 1, 0, 1},
        '{1,   0, 255, 0, 0, 0, 0}, '{2, 316,  10, 0, 0, 0, 0},
        '{2, 317,  10, 0, 1, 0, 0}, '{2, 401,  10, 0, 1, 0, 0},
        '{2, 402,  10, 0, 0, 0, 0}, '{2, 340, 250, 0, 1, 1, 1},
        '{2, 300, 250, 0, 1, 0, 1}, '{2,   0, 319, 0, 0, 0, 0}
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_cnt, ls_cnt, m;

        // Reset state, then one full 48K line.
        @(negedge clk); @(negedge clk);
        check_all();
        chk("rst_blank", 32'(bus_lo.blank), 1);
        chk("rst_active", 32'(bus_lo.active), 0);
        chk("rst_hsync_lo", 32'(bus_lo.hsync), 1);
        chk("rst_hsync_hi", 32'(bus_hi.hsync), 0);
        chk("rst_mode", 32'(bus_lo.mode_cur), 0);
        rst = 1'b0;
        hs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 1792; i++) begin
            tick(1);
            if (bus_lo.hsync == 1'b0) hs_cnt++;
            if (bus_lo.line_start) ls_cnt++;
        end
        chk("hsync_width_clk28", hs_cnt, 132);
        chk("line_start_per_line", ls_cnt, 1);

        // Decode table across all three rasters.
        for (int i = 0; i < 32; i++) begin
            jump(0, vt[i].hc, vt[i].vc, vt[i].mode);
            tick(1);
            chk("tbl_active", 32'(bus_lo.active), 32'(vt[i].act));
            chk("tbl_blank", 32'(bus_lo.blank), 32'(vt[i].blk));
            chk("tbl_hsync_lo", 32'(bus_lo.hsync), 32'(!vt[i].hs));
            chk("tbl_vsync_lo", 32'(bus_lo.vsync), 32'(!vt[i].vs));
            chk("tbl_csync_lo", 32'(bus_lo.csync), 32'(!(vt[i].hs ^ vt[i].vs)));
            chk("tbl_hsync_hi", 32'(bus_hi.hsync), 32'(vt[i].hs));
            chk("tbl_csync_hi", 32'(bus_hi.csync), 32'(vt[i].hs ^ vt[i].vs));
        end

        // Mode latch: mid-frame requests ignored, latch-cycle value wins.
        mode_req = 2'd0;
        jump(0, 200, 100, 0);
        mode_req = 2'd2;
        tick(20);
        chk("midframe_mode", 32'(bus_lo.mode_cur), 0);
        jump(0, 447, 311, 0);
        mode_req = 2'd1;
        tick(3);
        chk("latch_ce_pix", 32'(bus_lo.ce_pix), 1);
        chk("latch_mode_before", 32'(bus_lo.mode_cur), 0);
        mode_req = 2'd2;
        tick(1);
        chk("latch_mode_after", 32'(bus_lo.mode_cur), 2);
        chk("latch_frame_start", 32'(bus_lo.frame_start), 1);
        jump(3, 447, 311, 2);
        tick(1);
        chk("pent_vc_312", 32'(bus_lo.vc), 312);
        jump(3, 447, 319, 2);
        mode_req = 2'd1;
        tick(1);
        chk("pent_vc_wrap", 32'(bus_lo.vc), 0);
        chk("mode_128k", 32'(bus_lo.mode_cur), 1);
        jump(3, 447, 10, 1);
        tick(1);
        chk("128k_hc_448", 32'(bus_lo.hc), 448);
        jump(3, 455, 310, 1);
        mode_req = 2'd3;
        tick(1);
        chk("128k_frame_wrap", 32'(bus_lo.frame_start), 1);
        chk("alias_mode", 32'(bus_lo.mode_cur), 0);
        mode_req = 2'd0;

        // Blink over 32 frame wraps from a cleared frame counter.
        pulse_rst();
        for (int k = 1; k <= 32; k++) begin
            jump(3, 447, 311, 0);
            tick(1);
            chk("blink_frame_start", 32'(bus_lo.frame_start), 1);
            chk("blink_phase", 32'(bus_lo.blink), 32'((k % 32) >= 16));
        end

        // Asynchronous reset mid-line.
        jump(0, 200, 150, 0);
        tick(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_hc", 32'(bus_lo.hc), 0);
        chk("arst_vc", 32'(bus_lo.vc), 0);
        chk("arst_sub", 32'(bus_lo.sub), 0);
        chk("arst_blank", 32'(bus_lo.blank), 1);
        chk("arst_hsync_lo", 32'(bus_lo.hsync), 1);
        chk("arst_vsync_hi", 32'(bus_hi.vsync), 0);
        chk("arst_frame_start", 32'(bus_lo.frame_start), 1);
        @(negedge clk);
        rst = 1'b0;
        tick(10);

        // Randomized run with mode changes, jumps near wraps and reset pulses.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 20) begin
                mode_req = 2'($urandom_range(0, 3));
            end else if (r < 28) begin
                m = $urandom_range(0, 2);
                jump($urandom_range(0, 3), HT[m] - 1 - $urandom_range(0, 2),
                     VT[m] - 1 - $urandom_range(0, 1), m);
            end else if (r < 32) begin
                m = $urandom_range(0, 2);
                jump($urandom_range(0, 3), $urandom_range(0, HT[m] - 1),
                     $urandom_range(0, VT[m] - 1), m);
            end else if (r < 34) begin
                pulse_rst();
            end
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
